pipe_stage_skid_reg: RTL and testbench
======================================

Name: pipe_stage_skid_reg

Overview:
- Parametrised, elastic pipeline-stage register for the ID/EX class of boundaries and for any later stage boundary.
- Carries a control bundle and a data bundle, separately sized, from one stage to the next.
- Adds a valid/ready handshake, a 2-entry skid buffer so a stall need not propagate combinationally upstream, and a flush that turns in-flight entries into bubbles with zeroed control.
- Sits between two pipeline stages; the hazard unit drives flush, and the downstream stage drives out_ready.

Parameters:
- CTRL_W, 8: width of control bundle (regWrite, memToReg, memWrite, aluControl, aluSrc, regDst packed). Must be >= 1.
- DATA_W, 111: width of data bundle (rd1, rd2, rs, rt, rd, signImm packed). Must be >= 1.
- CLEAR_DATA, 1: 1 = flush/reset/bubble also zeroes the data bundle; 0 = data bundle holds its old value and only valid/ctrl are cleared.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept; registered, equals !skid_valid.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  main entry valid.
- out_ready  in  1  downstream accepts main entry this cycle.
- out_ctrl  out  CTRL_W  main control bundle; all-zero whenever out_valid=0.
- out_data  out  DATA_W  main data bundle.

Behaviour:
- State:
  - main entry (m_valid, m_ctrl, m_data) drives out_*.
  - skid entry (s_valid, s_ctrl, s_data) is internal.
  - in_ready = !s_valid, taken from a flop; it has no combinational path from out_ready.
- Reset (asynchronous, reset=1):
  - m_valid=0, s_valid=0, m_ctrl=0, s_ctrl=0, m_data=0, s_data=0 (data cleared regardless of CLEAR_DATA).
  - Outputs: in_ready=1, out_valid=0, out_ctrl=0, out_data=0.
  - Reset asserted mid-transfer discards both entries immediately, without waiting for a clock edge.
- Definitions: in_fire = in_valid & in_ready; out_fire = m_valid & out_ready.
- Next state at posedge, flush=0, evaluated in priority order:
  1. s_valid=1 and out_ready=1: main <- skid; s_valid <- 0. No input accepted, since in_ready=0.
  2. s_valid=1 and out_ready=0: hold both entries.
  3. m_valid=0 or out_ready=1: main <- input.
     - m_valid <- in_valid.
     - If in_valid=0, the stage loads a bubble: m_ctrl <- 0, and m_data <- 0 if CLEAR_DATA, otherwise m_data holds.
  4. m_valid=1, out_ready=0, in_valid=1: skid <- input; s_valid <- 1.
  5. Otherwise: hold.
- Flush (flush=1 at posedge): overrides every rule above.
  - m_valid <- 0, s_valid <- 0, m_ctrl <- 0, s_ctrl <- 0.
  - Data is zeroed only if CLEAR_DATA=1.
  - An in_fire in the same cycle counts as consumed by upstream and is discarded.
  - An out_fire in the same cycle is still a completed transfer downstream.
- Latency and throughput:
  - Empty stage: in -> out in 1 cycle.
  - With out_ready held high: 1 entry/cycle, and the skid entry is never used.
- Ordering: entries leave in acceptance order; the skid entry is always younger than the main entry.
- Capacity: at most 2 entries.
  - Full means s_valid=1, which forces in_ready=0 in the following cycles.
  - After the first out_fire, in_ready returns to 1 one cycle later.
- Invariants:
  - s_valid=1 implies m_valid=1.
  - out_ctrl != 0 implies out_valid=1.
  - in_ready never depends combinationally on any input.
- Upstream obligation: inputs are sampled only on in_fire. While in_ready=0, upstream holds its entry; the stage is not required to check this.

Test Plan:
- Reset then stream: reset=1 for 2 cycles, release; in_valid=1 on 4 consecutive cycles with in_ctrl=8'h01..8'h04 and out_ready=1 -> out_valid rises 1 cycle after the first beat; out_ctrl shows 01,02,03,04 on consecutive cycles; in_ready stays 1 throughout.
- Stall and skid: main holds ctrl 8'hA5; out_ready=0; in_valid=1 with ctrl 8'h5A -> skid captures 8'h5A; in_ready=0 next cycle; out_ctrl stays A5. Then raise out_ready -> out_ctrl shows A5, then 5A; in_ready=1 one cycle after the first out_fire.
- Flush with both entries full and in_valid=1 (ctrl 8'h77): pulse flush for 1 cycle -> next cycle out_valid=0, out_ctrl=0, in_ready=1; with CLEAR_DATA=1, out_data=0. The 8'h77 entry never appears at the output.
- Bubble insertion: in_valid=0 while the stage drains with out_ready=1 -> out_valid=0 and out_ctrl=0. With CLEAR_DATA=0, out_data keeps its last value.
- Asynchronous reset mid-stall: with s_valid=1, assert reset between clock edges -> out_valid=0, out_ctrl=0, out_data=0, and in_ready=1 without waiting for an edge. After release, the first accepted beat appears after 1 cycle.
- Random handshake soak: random in_valid, out_ready and flush (flush at ~5%) for 10k cycles against a 2-entry queue reference model -> zero ordering or data mismatches, and the invariants hold every cycle.

Source files
------------

// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: elastic pipeline register with 2-entry skid buffer and flush
module pipe_stage_skid_reg #(
    parameter int CTRL_W     = 8,
    parameter int DATA_W     = 111,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
);
    logic              m_valid, s_valid;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl;
    logic [DATA_W-1:0] m_data, s_data;

    assign in_ready  = !s_valid;
    assign out_valid = m_valid;
    assign out_ctrl  = m_ctrl;
    assign out_data  = m_data;

    // main/skid update: flush kills everything, skid drains first, else main loads or skid catches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_ctrl  <= '0;
            s_ctrl  <= '0;
            m_data  <= '0;
            s_data  <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_ctrl  <= '0;
            s_ctrl  <= '0;
            if (CLEAR_DATA) begin
                m_data <= '0;
                s_data <= '0;
            end
        end else if (s_valid) begin
            if (out_ready) begin
                m_ctrl  <= s_ctrl;
                m_data  <= s_data;
                s_valid <= 1'b0;
            end
        end else if (!m_valid || out_ready) begin
            m_valid <= in_valid;
            m_ctrl  <= in_valid ? in_ctrl : '0;
            if (in_valid) m_data <= in_data;
            else if (CLEAR_DATA) m_data <= '0;
        end else if (in_valid) begin
            s_valid <= 1'b1;
            s_ctrl  <= in_ctrl;
            s_data  <= in_data;
        end
    end
endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb_pipe_stage_skid_reg: directed vectors, corner sequences and queue-model soak
module tb_pipe_stage_skid_reg;
    logic         clk = 1'b0, reset = 1'b1, flush = 1'b0;
    logic         in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0]   in_ctrl = '0;
    logic [110:0] in_data = '0;
    logic         in_ready, out_valid, in_ready0, out_valid0;
    logic [7:0]   out_ctrl, out_ctrl0;
    logic [110:0] out_data, out_data0;
    int           total = 0, bad = 0;

    pipe_stage_skid_reg #(.CTRL_W(8), .DATA_W(111), .CLEAR_DATA(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data));

    pipe_stage_skid_reg #(.CTRL_W(8), .DATA_W(111), .CLEAR_DATA(1'b0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
        .out_ctrl(out_ctrl0), .out_data(out_data0));

    always #5 clk = ~clk;

    typedef struct {
        logic        iv, ordy, fl;
        logic [7:0]  c;
        logic [15:0] d;
        logic        ir, ov;
        logic [7:0]  oc;
        logic [15:0] od, od0;
    } vec_t;

    typedef struct {
        logic [7:0]   c;
        logic [110:0] d;
    } ent_t;

    vec_t         tv[18];
    ent_t         q[$];
    logic [110:0] last_shown;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_step();
        logic fire_in, fire_out;
        fire_in  = in_valid && q.size() < 2;
        fire_out = q.size() > 0 && out_ready;
        if (flush) q.delete();
        else begin
            if (fire_out) void'(q.pop_front());
            if (fire_in) q.push_back('{in_ctrl, in_data});
        end
        if (q.size() > 0) last_shown = q[0].d;
    endtask

    task automatic model_check();
        chk("soak_in_ready", 128'(in_ready), 128'(q.size() < 2));
        chk("soak_out_valid", 128'(out_valid), 128'(q.size() > 0));
        chk("soak_out_ctrl", 128'(out_ctrl), q.size() > 0 ? 128'(q[0].c) : 128'd0);
        chk("soak_out_data", 128'(out_data), q.size() > 0 ? 128'(q[0].d) : 128'd0);
        chk("soak_out_ctrl_nc", 128'(out_ctrl0), q.size() > 0 ? 128'(q[0].c) : 128'd0);
        chk("soak_out_data_nc", 128'(out_data0), 128'(last_shown));
        chk("soak_ctrl_implies_valid", 128'(out_ctrl == 8'd0 || out_valid), 128'd1);
    endtask

    initial begin
        //          iv ordy fl  c      d         ir ov oc     od        od0
        tv[0]  = '{1, 1, 0, 8'h01, 16'h0101, 1, 1, 8'h01, 16'h0101, 16'h0101};
        tv[1]  = '{1, 1, 0, 8'h02, 16'h0202, 1, 1, 8'h02, 16'h0202, 16'h0202};
        tv[2]  = '{1, 1, 0, 8'h03, 16'h0303, 1, 1, 8'h03, 16'h0303, 16'h0303};
        tv[3]  = '{1, 1, 0, 8'h04, 16'h0404, 1, 1, 8'h04, 16'h0404, 16'h0404};
        tv[4]  = '{0, 1, 0, 8'h00, 16'h0000, 1, 0, 8'h00, 16'h0000, 16'h0404};
        tv[5]  = '{1, 0, 0, 8'hA5, 16'h00A5, 1, 1, 8'hA5, 16'h00A5, 16'h00A5};
        tv[6]  = '{1, 0, 0, 8'h5A, 16'h005A, 0, 1, 8'hA5, 16'h00A5, 16'h00A5};
        tv[7]  = '{1, 0, 0, 8'h66, 16'h0066, 0, 1, 8'hA5, 16'h00A5, 16'h00A5};
        tv[8]  = '{1, 1, 0, 8'h66, 16'h0066, 1, 1, 8'h5A, 16'h005A, 16'h005A};
        tv[9]  = '{1, 1, 0, 8'h66, 16'h0066, 1, 1, 8'h66, 16'h0066, 16'h0066};
        tv[10] = '{1, 0, 0, 8'h11, 16'h0011, 0, 1, 8'h66, 16'h0066, 16'h0066};
        tv[11] = '{1, 0, 1, 8'h77, 16'h0077, 1, 0, 8'h00, 16'h0000, 16'h0066};
        tv[12] = '{0, 1, 0, 8'h00, 16'h0000, 1, 0, 8'h00, 16'h0000, 16'h0066};
        tv[13] = '{1, 0, 0, 8'h22, 16'h0022, 1, 1, 8'h22, 16'h0022, 16'h0022};
        tv[14] = '{1, 1, 1, 8'h33, 16'h0033, 1, 0, 8'h00, 16'h0000, 16'h0022};
        tv[15] = '{1, 1, 0, 8'h44, 16'h0044, 1, 1, 8'h44, 16'h0044, 16'h0044};
        tv[16] = '{0, 0, 0, 8'h00, 16'h0000, 1, 1, 8'h44, 16'h0044, 16'h0044};
        tv[17] = '{0, 1, 0, 8'h00, 16'h0000, 1, 0, 8'h00, 16'h0000, 16'h0044};

        tick();
        tick();
        chk("reset_in_ready", 128'(in_ready), 128'd1);
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_out_ctrl", 128'(out_ctrl), 128'd0);
        chk("reset_out_data", 128'(out_data), 128'd0);
        reset = 1'b0;

        foreach (tv[i]) begin
            in_valid  = tv[i].iv;
            out_ready = tv[i].ordy;
            flush     = tv[i].fl;
            in_ctrl   = tv[i].c;
            in_data   = 111'(tv[i].d);
            tick();
            chk($sformatf("vec%0d_in_ready", i), 128'(in_ready), 128'(tv[i].ir));
            chk($sformatf("vec%0d_out_valid", i), 128'(out_valid), 128'(tv[i].ov));
            chk($sformatf("vec%0d_out_ctrl", i), 128'(out_ctrl), 128'(tv[i].oc));
            chk($sformatf("vec%0d_out_data", i), 128'(out_data), 128'(tv[i].od));
            chk($sformatf("vec%0d_out_data_nc", i), 128'(out_data0), 128'(tv[i].od0));
        end
        flush = 1'b0;

        // fill both entries, then reset between edges
        in_valid = 1'b1; out_ready = 1'b0; in_ctrl = 8'hA1; in_data = 111'h0A1;
        tick();
        in_ctrl = 8'hA2; in_data = 111'h0A2;
        tick();
        chk("stall_full_in_ready", 128'(in_ready), 128'd0);
        #3 reset = 1'b1;
        #1;
        chk("async_in_ready", 128'(in_ready), 128'd1);
        chk("async_out_valid", 128'(out_valid), 128'd0);
        chk("async_out_ctrl", 128'(out_ctrl), 128'd0);
        chk("async_out_data", 128'(out_data), 128'd0);
        chk("async_out_data_nc", 128'(out_data0), 128'd0);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1; in_ctrl = 8'hB1; in_data = 111'h0B1;
        tick();
        chk("post_reset_out_valid", 128'(out_valid), 128'd1);
        chk("post_reset_out_ctrl", 128'(out_ctrl), 128'hB1);
        chk("post_reset_out_data", 128'(out_data), 128'h0B1);

        // random soak against a 2-entry queue
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q.delete();
        last_shown = '0;
        for (int n = 0; n < 10000; n++) begin
            logic [127:0] r;
            if (!(in_valid && !in_ready)) begin
                r        = {$urandom(), $urandom(), $urandom(), $urandom()};
                in_valid = 1'($urandom_range(0, 1));
                in_ctrl  = 8'($urandom());
                in_data  = r[110:0];
            end
            out_ready = 1'($urandom_range(0, 1));
            flush     = $urandom_range(0, 99) < 5;
            @(posedge clk);
            model_step();
            #1;
            model_check();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
